// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and op classification for alu_multicycle (ALU_DIV_EN adds DIV/REM)
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_SR   = 4'b0110;
  localparam logic [3:0] OP_SL   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BLT  = 4'b1011;
  localparam logic [3:0] OP_BGE  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_MULH = 4'b1110;
  localparam logic [3:0] OP_REM  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
`else
    return (op == OP_MUL) || (op == OP_MULH);
`endif
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - request/response handshake bundle between the EX stage and alu_multicycle
interface alu_multicycle_if #(parameter int WIDTH = 32);

  logic             In_Valid_i;
  logic             In_Ready_o;
  logic [3:0]       ALU_Operation_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             Out_Valid_o;
  logic             Out_Ready_i;
  logic [WIDTH-1:0] ALU_Result_o;
  logic             Zero_o;
  logic             Busy_o;

  modport master (
    output In_Valid_i, ALU_Operation_i, A_i, B_i, Out_Ready_i,
    input  In_Ready_o, Out_Valid_o, ALU_Result_o, Zero_o, Busy_o
  );

  modport slave (
    input  In_Valid_i, ALU_Operation_i, A_i, B_i, Out_Ready_i,
    output In_Ready_o, Out_Valid_o, ALU_Result_o, Zero_o, Busy_o
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiplier / restoring divider on magnitudes (divider under ALU_DIV_EN)
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic                 run_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     mcand_q;
  logic [3:0]           op_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
`ifdef ALU_DIV_EN
  logic                 div_q;
  logic                 aneg_q;
  logic                 bzero_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH:0]       trial;
  logic                 start_div;

  assign start_div = (op_i == OP_DIV) || (op_i == OP_REM);
`endif

  assign a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
  assign done_o = run_q && (cnt_q == CNT_W'(WIDTH - 1));

  // {hi,lo} is the product shifting right (MUL) or remainder:quotient shifting left (DIV)
  always_comb begin
    sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
    hi_d = sum[WIDTH:1];
    lo_d = {sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    trial = '0;
    if (div_q) begin
      trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, mcand_q};
      if (trial[WIDTH]) begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  // Result is taken from the final step's next-state so the top can register it on the done edge
  always_comb begin
    prod = {hi_d, lo_d};
    if (neg_q) prod = -prod;
    result_o = (op_q == OP_MULH) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
    if (div_q) begin
      if (bzero_q)
        result_o = (op_q == OP_DIV) ? '1 : a_q;
      else if (op_q == OP_DIV)
        result_o = neg_q ? -lo_d : lo_d;
      else
        result_o = aneg_q ? -hi_d : hi_d;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
`ifdef ALU_DIV_EN
      div_q   <= 1'b0;
      aneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      a_q     <= '0;
`endif
    end else if (start_i) begin
      run_q   <= 1'b1;
      cnt_q   <= '0;
      hi_q    <= '0;
      op_q    <= op_i;
      neg_q   <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      lo_q    <= b_mag;
      mcand_q <= a_mag;
`ifdef ALU_DIV_EN
      div_q   <= start_div;
      aneg_q  <= a_i[WIDTH-1];
      bzero_q <= (b_i == '0);
      a_q     <= a_i;
      if (start_div) begin
        lo_q    <= a_mag;
        mcand_q <= b_mag;
      end
`endif
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - RV32I ALU with valid/ready handshake and iterative MUL/MULH (DIV/REM with ALU_DIV_EN)
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  alu_multicycle_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               md_start;
  logic               md_done;
  logic [WIDTH-1:0]   md_result;
  logic [WIDTH-1:0]   comb_result;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = bus.B_i[SHAMT_W-1:0];

  // Branch ops return zero when taken so Zero_o doubles as the taken flag
  always_comb begin
    comb_result = '0;
    case (bus.ALU_Operation_i)
      OP_ADD:  comb_result = bus.A_i + bus.B_i;
      OP_SUB:  comb_result = bus.A_i - bus.B_i;
      OP_AND:  comb_result = bus.A_i & bus.B_i;
      OP_OR:   comb_result = bus.A_i | bus.B_i;
      OP_XOR:  comb_result = bus.A_i ^ bus.B_i;
      OP_LUI:  comb_result = bus.B_i << 12;
      OP_SR:   comb_result = bus.A_i >> shamt;
      OP_SL:   comb_result = bus.A_i << shamt;
      OP_BEQ:  comb_result = (bus.A_i == bus.B_i) ? '0 : '1;
      OP_BNE:  comb_result = (bus.A_i != bus.B_i) ? '0 : '1;
      OP_BLT:  comb_result = ($signed(bus.A_i) <  $signed(bus.B_i)) ? '0 : '1;
      OP_BGE:  comb_result = ($signed(bus.A_i) >= $signed(bus.B_i)) ? '0 : '1;
      default: comb_result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    md_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.In_Valid_i) begin
          if (is_iterative(bus.ALU_Operation_i)) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            result_d = comb_result;
            zero_d   = (comb_result == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          result_d = md_result;
          zero_d   = (md_result == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.Out_Ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (md_start),
    .op_i     (bus.ALU_Operation_i),
    .a_i      (bus.A_i),
    .b_i      (bus.B_i),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign bus.In_Ready_o   = (state_q == ST_IDLE);
  assign bus.Out_Valid_o  = (state_q == ST_DONE);
  assign bus.Busy_o       = (state_q == ST_BUSY);
  assign bus.ALU_Result_o = result_q;
  assign bus.Zero_o       = zero_q;

endmodule
